// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU operation codes, forward selects,
// and the control-bit bundle carried from ID/EX into EX/MEM.
package pipeline_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_alu32.sv
// Combinational ALU for the execute stage.
// Unknown operation codes produce 0.
module alu32
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic slt;

    assign slt = ($signed(a) < $signed(b));

    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, and the EX/MEM register.
// EX/MEM priority per edge is flush, then stall, then normal load.
module ex_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic [3:0]       alu_operation,
    input  logic [RADDR-1:0] dest,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             id_valid,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] exmem_alu_result,
    output logic             exmem_zero,
    output logic [WIDTH-1:0] exmem_write_data,
    output logic [RADDR-1:0] exmem_dest,
    output logic             exmem_reg_write,
    output logic             exmem_mem_read,
    output logic             exmem_mem_write,
    output logic             exmem_mem_to_reg,
    output logic             exmem_valid
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] fwd_rt;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    ctrl_t            ctrl_in;
    ctrl_t            ctrl_q;

    // Select 11 is unused by the hazard unit and falls back to the register file.
    function automatic logic [WIDTH-1:0] fwd_mux(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] reg_val,
        input logic [WIDTH-1:0] exmem_val,
        input logic [WIDTH-1:0] wb_val
    );
        case (sel)
            FWD_EXMEM: return exmem_val;
            FWD_WB:    return wb_val;
            default:   return reg_val;
        endcase
    endfunction

    assign op_a   = fwd_mux(forward_a, rs_data, exmem_alu_result, wb_data);
    assign fwd_rt = fwd_mux(forward_b, rt_data, exmem_alu_result, wb_data);
    assign op_b   = alu_src ? imm : fwd_rt;

    alu32 #(.WIDTH(WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (alu_operation),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Gating with id_valid keeps a bubble from ever writing state downstream.
    assign ctrl_in = '{
        reg_write:  reg_write  & id_valid,
        mem_read:   mem_read   & id_valid,
        mem_write:  mem_write  & id_valid,
        mem_to_reg: mem_to_reg & id_valid
    };

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_alu_result <= '0;
            exmem_zero       <= 1'b0;
            exmem_write_data <= '0;
            exmem_dest       <= '0;
            ctrl_q           <= '0;
            exmem_valid      <= 1'b0;
        end else if (flush) begin
            exmem_alu_result <= '0;
            exmem_zero       <= 1'b0;
            exmem_write_data <= '0;
            exmem_dest       <= '0;
            ctrl_q           <= '0;
            exmem_valid      <= 1'b0;
        end else if (!stall) begin
            exmem_alu_result <= alu_result;
            exmem_zero       <= alu_zero;
            exmem_write_data <= fwd_rt;
            exmem_dest       <= dest;
            ctrl_q           <= ctrl_in;
            exmem_valid      <= id_valid;
        end
    end

    assign exmem_reg_write  = ctrl_q.reg_write;
    assign exmem_mem_read   = ctrl_q.mem_read;
    assign exmem_mem_write  = ctrl_q.mem_write;
    assign exmem_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes model predictions,
// monitor pops one per clock edge (or reset assertion) and compares.
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [31:0] rs_data, rt_data, imm, wb_data;
    logic        alu_src;
    logic [3:0]  alu_operation;
    logic [4:0]  dest;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic        id_valid;
    logic [1:0]  forward_a, forward_b;
    logic        stall, flush;
    logic [31:0] exmem_alu_result, exmem_write_data;
    logic        exmem_zero;
    logic [4:0]  exmem_dest;
    logic        exmem_reg_write, exmem_mem_read;
    logic        exmem_mem_write, exmem_mem_to_reg;
    logic        exmem_valid;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic [31:0] wd;
        logic [4:0]  dst;
        logic [3:0]  ctl;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   errors = 0;
    int   checks = 0;

    ex_stage dut (
        .clk              (clk),
        .reset            (reset),
        .rs_data          (rs_data),
        .rt_data          (rt_data),
        .imm              (imm),
        .alu_src          (alu_src),
        .alu_operation    (alu_operation),
        .dest             (dest),
        .reg_write        (reg_write),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_to_reg       (mem_to_reg),
        .id_valid         (id_valid),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .wb_data          (wb_data),
        .stall            (stall),
        .flush            (flush),
        .exmem_alu_result (exmem_alu_result),
        .exmem_zero       (exmem_zero),
        .exmem_write_data (exmem_write_data),
        .exmem_dest       (exmem_dest),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_mem_write  (exmem_mem_write),
        .exmem_mem_to_reg (exmem_mem_to_reg),
        .exmem_valid      (exmem_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] alu_ref(
        input logic [31:0] a, input logic [31:0] b, input logic [3:0] op
    );
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(
        input logic [1:0] sel, input logic [31:0] regv,
        input logic [31:0] prev, input logic [31:0] wb
    );
        if (sel == 2'b10) return prev;
        if (sel == 2'b01) return wb;
        return regv;
    endfunction

    // Predict EX/MEM after the coming edge from the current inputs.
    task automatic issue();
        logic [31:0] a, rtf, b, r;
        a   = pick(forward_a, rs_data, m.res, wb_data);
        rtf = pick(forward_b, rt_data, m.res, wb_data);
        b   = alu_src ? imm : rtf;
        r   = alu_ref(a, b, alu_operation);
        if (flush) begin
            m = '0;
        end else if (!stall) begin
            m.res = r;
            m.z   = (r == 32'd0);
            m.wd  = rtf;
            m.dst = dest;
            m.ctl = id_valid ? {reg_write, mem_read, mem_write, mem_to_reg}
                             : 4'b0000;
            m.v   = id_valid;
        end
        exp_q.push_back(m);
    endtask

    task automatic apply(
        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
        input logic src, input logic [3:0] op, input logic [4:0] d,
        input logic [3:0] ctl, input logic idv, input logic [1:0] fa,
        input logic [1:0] fb, input logic [31:0] wb,
        input logic st, input logic fl
    );
        rs_data = rs;
        rt_data = rt;
        imm = im;
        alu_src = src;
        alu_operation = op;
        dest = d;
        {reg_write, mem_read, mem_write, mem_to_reg} = ctl;
        id_valid = idv;
        forward_a = fa;
        forward_b = fb;
        wb_data = wb;
        stall = st;
        flush = fl;
        issue();
    endtask

    task automatic step(
        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
        input logic src, input logic [3:0] op, input logic [4:0] d,
        input logic [3:0] ctl, input logic idv, input logic [1:0] fa,
        input logic [1:0] fb, input logic [31:0] wb,
        input logic st, input logic fl
    );
        @(negedge clk);
        apply(rs, rt, im, src, op, d, ctl, idv, fa, fb, wb, st, fl);
    endtask

    // Pulse reset between edges; the monitor checks on its rising edge.
    task automatic mid_reset();
        @(negedge clk);
        m = '0;
        exp_q.push_back(m);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        logic [3:0] ops [6];
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        if ($urandom_range(0, 7) == 0) return 4'($urandom);
        return ops[$urandom_range(0, 5)];
    endfunction

    initial begin : monitor
        exp_t e, act;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {exmem_alu_result, exmem_zero, exmem_write_data,
                       exmem_dest, exmem_reg_write, exmem_mem_read,
                       exmem_mem_write, exmem_mem_to_reg, exmem_valid};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL exmem t=%0t got res=%h z=%b wd=%h d=%0d c=%b v=%b exp res=%h z=%b wd=%h d=%0d c=%b v=%b",
                             $time, act.res, act.z, act.wd, act.dst, act.ctl,
                             act.v, e.res, e.z, e.wd, e.dst, e.ctl, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b0;
        m = '0;
        apply(0, 0, 0, 0, 4'd0, 0, 4'b0000, 0, 2'b00, 2'b00, 0, 0, 0);
        exp_q.delete();
        mid_reset();
        apply(5, 7, 0, 0, 4'd2, 5'd3, 4'b1000, 1, 2'b00, 2'b00, 0, 0, 0);
        step(32'hFFFF_FFFF, 1, 0, 0, 4'd7, 5'd4, 4'b1000, 1, 2'b00, 2'b00, 0, 0, 0);
        step(9, 9, 0, 0, 4'd6, 5'd5, 4'b1000, 1, 2'b00, 2'b00, 0, 0, 0);
        step(0, 1, 0, 0, 4'd6, 5'd6, 4'b1000, 1, 2'b00, 2'b00, 0, 0, 0);
        step(3, 4, 0, 0, 4'd2, 5'd7, 4'b1000, 1, 2'b00, 2'b00, 0, 0, 0);
        step(99, 1, 0, 0, 4'd2, 5'd8, 4'b1000, 1, 2'b10, 2'b00, 0, 0, 0);
        step(2, 55, 0, 0, 4'd6, 5'd9, 4'b1000, 1, 2'b00, 2'b01, 20, 0, 0);
        step(0, 77, 100, 1, 4'd2, 5'd10, 4'b0010, 1, 2'b00, 2'b10, 0, 0, 0);
        step(5, 7, 0, 0, 4'd2, 5'd11, 4'b1101, 1, 2'b00, 2'b00, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step($urandom, $urandom, $urandom, 1'($urandom), rnd_op(),
                 5'($urandom), 4'($urandom), 1, 2'($urandom), 2'($urandom),
                 $urandom, 1, 0);
        step(1, 2, 0, 0, 4'd2, 5'd12, 4'b1111, 1, 2'b00, 2'b00, 0, 1, 1);
        step(8, 8, 0, 0, 4'd1, 5'd13, 4'b1001, 1, 2'b00, 2'b00, 0, 0, 0);
        step(4, 4, 0, 0, 4'd2, 5'd14, 4'b1010, 0, 2'b00, 2'b00, 0, 0, 0);
        step(6, 1, 0, 0, 4'd2, 5'd15, 4'b1100, 1, 2'b00, 2'b00, 0, 0, 0);
        mid_reset();
        apply(5, 3, 0, 0, 4'b1111, 5'd16, 4'b1000, 1, 2'b00, 2'b00, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step(rnd_val(), rnd_val(), rnd_val(), 1'($urandom), rnd_op(),
                 5'($urandom), 4'($urandom), ($urandom_range(0, 5) != 0),
                 2'($urandom), 2'($urandom), rnd_val(),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            if (i % 97 == 50) begin
                mid_reset();
                apply(rnd_val(), rnd_val(), rnd_val(), 1'($urandom), rnd_op(),
                      5'($urandom), 4'($urandom), 1, 2'($urandom),
                      2'($urandom), rnd_val(), 0, 0);
            end
        end
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
